// File: rtl/a_star_pkg.sv
// Shared A* open-list definitions: entry layout, field offsets and the rescoring FSM states.
package a_star_pkg;

  localparam int unsigned COL_WIDTH   = 4;
  localparam int unsigned ROW_WIDTH   = 4;
  localparam int unsigned F_WIDTH     = 8;
  localparam int unsigned H_WIDTH     = 7;
  localparam int unsigned SPARE_WIDTH = 8;

  // Offsets chain from bit 0 upward so the layout stays self-consistent.
  localparam int unsigned EMPTY_BIT   = 0;
  localparam int unsigned SPARE_LSB   = EMPTY_BIT + 1;
  localparam int unsigned H_LSB       = SPARE_LSB + SPARE_WIDTH;
  localparam int unsigned F_LSB       = H_LSB + H_WIDTH;
  localparam int unsigned ROW_LSB     = F_LSB + F_WIDTH;
  localparam int unsigned COL_LSB     = ROW_LSB + ROW_WIDTH;
  localparam int unsigned ENTRY_WIDTH = COL_LSB + COL_WIDTH;

  typedef struct packed {
    logic [COL_WIDTH-1:0]   col;
    logic [ROW_WIDTH-1:0]   row;
    logic [F_WIDTH-1:0]     f;
    logic [H_WIDTH-1:0]     h;
    logic [SPARE_WIDTH-1:0] spare;
    logic                   empty;
  } open_entry_t;

  typedef enum logic [1:0] {StIdle, StSweep, StDrain, StDone} rescore_state_e;

  function automatic open_entry_t to_entry(logic [ENTRY_WIDTH-1:0] raw);
    return open_entry_t'(raw);
  endfunction

endpackage

// File: rtl/updateQueue.sv
// F/H rescoring unit: Manhattan H to the goal, F = g + H, one registered stage.
module updateQueue
  import a_star_pkg::*;
#(
  parameter int unsigned G_SCORE_WIDTH = 7,
  parameter int unsigned GOAL_CELL_COL = 9,
  parameter int unsigned GOAL_CELL_ROW = 9
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     valid_i,
  input  open_entry_t              entry_i,
  input  logic [G_SCORE_WIDTH-1:0] g_score_i,
  output logic                     valid_o,
  output open_entry_t              entry_o
);

  localparam logic [COL_WIDTH-1:0] GoalCol = COL_WIDTH'(GOAL_CELL_COL);
  localparam logic [ROW_WIDTH-1:0] GoalRow = ROW_WIDTH'(GOAL_CELL_ROW);

  logic [COL_WIDTH-1:0] dcol;
  logic [ROW_WIDTH-1:0] drow;
  logic [H_WIDTH-1:0]   h;
  open_entry_t          entry_d;

  always_comb begin
    dcol    = (entry_i.col >= GoalCol) ? entry_i.col - GoalCol : GoalCol - entry_i.col;
    drow    = (entry_i.row >= GoalRow) ? entry_i.row - GoalRow : GoalRow - entry_i.row;
    h       = H_WIDTH'(dcol) + H_WIDTH'(drow);
    entry_d = entry_i;
    // Empty slots pass through untouched so the writeback is a no-op for them.
    if (!entry_i.empty) begin
      entry_d.h = h;
      entry_d.f = F_WIDTH'(g_score_i) + F_WIDTH'(h);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_o <= 1'b0;
      entry_o <= '0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) entry_o <= entry_d;
    end
  end

endmodule

// File: rtl/open_list_rescore_ctrl.sv
// Sweeps every open-list slot through the rescoring unit, writes it back in place and
// reports the lowest-F live slot as the next node to expand.
module open_list_rescore_ctrl
  import a_star_pkg::*;
#(
  parameter int unsigned DATA_WIDTH        = 32,
  parameter int unsigned CELL_COLUMN_WIDTH = 4,
  parameter int unsigned CELL_ROW_WIDTH    = 4,
  parameter int unsigned G_SCORE_WIDTH     = 7,
  parameter int unsigned F_SCORE_WIDTH     = 8,
  parameter int unsigned QUEUE_DEPTH       = 16,
  parameter int unsigned ADDR_WIDTH        = $clog2(QUEUE_DEPTH),
  parameter int unsigned GOAL_CELL_COL     = 9,
  parameter int unsigned GOAL_CELL_ROW     = 9
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      start,
  input  logic [G_SCORE_WIDTH-1:0]                  g_score,
  output logic                                      busy,
  output logic                                      done,
  output logic                                      best_valid,
  output logic [ADDR_WIDTH-1:0]                     best_idx,
  output logic [CELL_COLUMN_WIDTH+CELL_ROW_WIDTH-1:0] best_cell,
  output logic [F_SCORE_WIDTH-1:0]                  best_f,
  output logic                                      mem_rd_en,
  output logic [ADDR_WIDTH-1:0]                     mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]                     mem_rd_data,
  output logic                                      mem_wr_en,
  output logic [ADDR_WIDTH-1:0]                     mem_wr_addr,
  output logic [DATA_WIDTH-1:0]                     mem_wr_data
);

  localparam int unsigned CellWidth = CELL_COLUMN_WIDTH + CELL_ROW_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(QUEUE_DEPTH - 1);

  rescore_state_e             state_q;
  logic [G_SCORE_WIDTH-1:0]   g_q;
  logic                       rd_en_q, busy_q, done_q, drain_q;
  logic [ADDR_WIDTH-1:0]      rd_addr_q;
  logic                       in_valid_q;
  logic [ADDR_WIDTH-1:0]      addr_s1_q, addr_s2_q;

  logic                       upd_valid;
  open_entry_t                upd_entry;

  logic                       run_valid_q, run_valid_d;
  logic [ADDR_WIDTH-1:0]      run_idx_q, run_idx_d;
  logic [CellWidth-1:0]       run_cell_q, run_cell_d;
  logic [F_SCORE_WIDTH-1:0]   run_f_q, run_f_d;

  logic                       best_valid_q;
  logic [ADDR_WIDTH-1:0]      best_idx_q;
  logic [CellWidth-1:0]       best_cell_q;
  logic [F_SCORE_WIDTH-1:0]   best_f_q;

  updateQueue #(
    .G_SCORE_WIDTH(G_SCORE_WIDTH),
    .GOAL_CELL_COL(GOAL_CELL_COL),
    .GOAL_CELL_ROW(GOAL_CELL_ROW)
  ) u_update (
    .clk      (clk),
    .rst      (rst),
    .valid_i  (in_valid_q),
    .entry_i  (to_entry(mem_rd_data)),
    .g_score_i(g_q),
    .valid_o  (upd_valid),
    .entry_o  (upd_entry)
  );

  // Strict less-than keeps the lowest index on F ties.
  always_comb begin
    run_valid_d = run_valid_q;
    run_idx_d   = run_idx_q;
    run_cell_d  = run_cell_q;
    run_f_d     = run_f_q;
    if (upd_valid && !upd_entry.empty && (!run_valid_q || upd_entry.f < run_f_q)) begin
      run_valid_d = 1'b1;
      run_idx_d   = addr_s2_q;
      run_cell_d  = {upd_entry.col, upd_entry.row};
      run_f_d     = upd_entry.f;
    end
  end

  // Slot address rides alongside the RAM read and the updater stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      in_valid_q <= 1'b0;
      addr_s1_q  <= '0;
      addr_s2_q  <= '0;
    end else begin
      in_valid_q <= rd_en_q;
      addr_s1_q  <= rd_addr_q;
      addr_s2_q  <= addr_s1_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StIdle;
      g_q          <= '0;
      rd_en_q      <= 1'b0;
      rd_addr_q    <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      drain_q      <= 1'b0;
      run_valid_q  <= 1'b0;
      run_idx_q    <= '0;
      run_cell_q   <= '0;
      run_f_q      <= '0;
      best_valid_q <= 1'b0;
      best_idx_q   <= '0;
      best_cell_q  <= '0;
      best_f_q     <= '0;
    end else begin
      done_q      <= 1'b0;
      run_valid_q <= run_valid_d;
      run_idx_q   <= run_idx_d;
      run_cell_q  <= run_cell_d;
      run_f_q     <= run_f_d;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            g_q         <= g_score;
            run_valid_q <= 1'b0;
            run_idx_q   <= '0;
            run_cell_q  <= '0;
            run_f_q     <= '0;
            rd_en_q     <= 1'b1;
            rd_addr_q   <= '0;
            busy_q      <= 1'b1;
            state_q     <= StSweep;
          end
        end
        StSweep: begin
          if (rd_addr_q == LastAddr) begin
            rd_en_q <= 1'b0;
            drain_q <= 1'b0;
            state_q <= StDrain;
          end else begin
            rd_addr_q <= rd_addr_q + 1'b1;
          end
        end
        StDrain: begin
          if (drain_q) begin
            // The final writeback is folded in via the _d values on this edge.
            best_valid_q <= run_valid_d;
            best_idx_q   <= run_idx_d;
            best_cell_q  <= run_cell_d;
            best_f_q     <= run_f_d;
            done_q       <= 1'b1;
            state_q      <= StDone;
          end else begin
            drain_q <= 1'b1;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign best_valid  = best_valid_q;
  assign best_idx    = best_idx_q;
  assign best_cell   = best_cell_q;
  assign best_f      = best_f_q;
  assign mem_rd_en   = rd_en_q;
  assign mem_rd_addr = rd_addr_q;
  assign mem_wr_en   = upd_valid;
  assign mem_wr_addr = addr_s2_q;
  assign mem_wr_data = upd_entry;

endmodule

// File: tb/tb_open_list_rescore_ctrl.sv
// Bench for open_list_rescore_ctrl: RAM model, directed and random passes against a
// behavioural rescoring model.
module tb_open_list_rescore_ctrl;

  localparam int N = 4;

  logic        clk = 1'b0;
  logic        rst, start, load_en;
  logic [6:0]  g_score;
  logic        busy, done, best_valid, mem_rd_en, mem_wr_en;
  logic [1:0]  best_idx, mem_rd_addr, mem_wr_addr;
  logic [7:0]  best_cell, best_f;
  logic [31:0] mem_rd_data, mem_wr_data;

  logic [31:0] mem      [N];
  logic [31:0] init_mem [N];
  logic [31:0] exp_mem  [N];
  logic        exp_valid;
  logic [1:0]  exp_idx;
  logic [7:0]  exp_cell, exp_f;

  int checks = 0;
  int errors = 0;

  logic [58:0] all_out;
  assign all_out = {busy, done, best_valid, best_idx, best_cell, best_f, mem_rd_en, mem_rd_addr,
                    mem_wr_en, mem_wr_addr, mem_wr_data};

  always #5 clk = ~clk;

  open_list_rescore_ctrl #(
    .QUEUE_DEPTH(N),
    .ADDR_WIDTH (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .g_score    (g_score),
    .busy       (busy),
    .done       (done),
    .best_valid (best_valid),
    .best_idx   (best_idx),
    .best_cell  (best_cell),
    .best_f     (best_f),
    .mem_rd_en  (mem_rd_en),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .mem_wr_en  (mem_wr_en),
    .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data)
  );

  // Synchronous-read RAM: data appears the cycle after the strobe.
  always @(posedge clk) begin
    if (load_en) begin
      for (int i = 0; i < N; i++) mem[i] <= init_mem[i];
    end else if (mem_wr_en) begin
      mem[mem_wr_addr] <= mem_wr_data;
    end
    if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mk(input int col, input int row, input bit empty);
    logic [31:0] r;
    r       = $urandom;
    r[31:28] = col[3:0];
    r[27:24] = row[3:0];
    r[0]     = empty;
    return r;
  endfunction

  // Reference: Manhattan distance to (9,9), F = g + H, empty slots unchanged.
  function automatic logic [31:0] rescore(input logic [31:0] e, input int g);
    int col, row, h, f;
    logic [31:0] r;
    if (e[0]) return e;
    col = int'(e[31:28]);
    row = int'(e[27:24]);
    h = ((col > 9) ? col - 9 : 9 - col) + ((row > 9) ? row - 9 : 9 - row);
    f = g + h;
    r = e;
    r[23:16] = f[7:0];
    r[15:9]  = h[6:0];
    return r;
  endfunction

  task automatic build_expect(input int g);
    exp_valid = 1'b0;
    exp_idx   = '0;
    exp_cell  = '0;
    exp_f     = '0;
    for (int i = 0; i < N; i++) begin
      exp_mem[i] = rescore(init_mem[i], g);
      if (!exp_mem[i][0] && (!exp_valid || exp_mem[i][23:16] < exp_f)) begin
        exp_valid = 1'b1;
        exp_idx   = 2'(i);
        exp_cell  = exp_mem[i][31:24];
        exp_f     = exp_mem[i][23:16];
      end
    end
  endtask

  // One pass; g_chg/restart/rst_at give the cycle (start edge = 0) of each disturbance, 0 = none.
  task automatic run_pass(input string name, input logic [6:0] g, input int g_chg,
                          input int restart, input int rst_at);
    int wr_idx = 0;
    int done_cnt = 0;
    int done_cyc = -1;
    bit aborted = 0;
    build_expect(int'(g));
    @(negedge clk);
    load_en = 1'b1;
    @(negedge clk);
    load_en = 1'b0;
    start   = 1'b1;
    g_score = g;
    for (int cyc = 1; cyc <= N + 8; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start = 1'b0;
      if (!aborted) begin
        if (cyc <= N) check({name, "_rd"}, {mem_rd_en, mem_rd_addr}, {1'b1, 2'(cyc - 1)});
        else check({name, "_rd_idle"}, mem_rd_en, 0);
        check({name, "_busy"}, busy, (cyc <= N + 3));
        if (mem_wr_en) begin
          if (wr_idx < N) begin
            check({name, "_wr_cycle"}, cyc, wr_idx + 3);
            check({name, "_wr_addr"}, mem_wr_addr, wr_idx);
            check({name, "_wr_data"}, mem_wr_data, exp_mem[wr_idx]);
          end
          wr_idx++;
        end
        if (mem_wr_en && mem_rd_en) check({name, "_rd_wr_same"}, mem_rd_addr == mem_wr_addr, 0);
        if (done) begin
          done_cnt++;
          done_cyc = cyc;
          check({name, "_best"}, {best_valid, best_idx, best_cell, best_f},
                {exp_valid, exp_idx, exp_cell, exp_f});
        end
        if (cyc == N + 6)
          check({name, "_best_hold"}, {best_valid, best_idx, best_cell, best_f},
                {exp_valid, exp_idx, exp_cell, exp_f});
      end else begin
        if (cyc == rst_at + 1) check({name, "_rst_outputs"}, all_out, 0);
        check({name, "_rst_no_wr"}, mem_wr_en, 0);
        if (done) done_cnt++;
      end
      if (cyc == g_chg) g_score = 7'd50;
      if (cyc == restart) start = 1'b1;
      if (cyc == restart + 1 && restart != 0) start = 1'b0;
      if (cyc == rst_at) begin
        rst = 1'b1;
        aborted = 1;
      end
      if (cyc == rst_at + 1 && rst_at != 0) rst = 1'b0;
    end
    if (!aborted) begin
      check({name, "_done_cnt"}, done_cnt, 1);
      check({name, "_done_cyc"}, done_cyc, N + 3);
      check({name, "_wr_cnt"}, wr_idx, N);
      for (int i = 0; i < N; i++) check({name, "_mem"}, mem[i], exp_mem[i]);
    end else begin
      check({name, "_rst_done_cnt"}, done_cnt, 0);
      for (int i = 0; i < N; i++) check({name, "_rst_mem"}, mem[i], init_mem[i]);
    end
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b0;
    load_en = 1'b0;
    g_score = '0;
    repeat (2) @(negedge clk);
    check("reset_outputs", all_out, 0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_outputs", all_out, 0);

    init_mem[0] = mk(0, 0, 0);
    init_mem[1] = mk(9, 9, 0);
    init_mem[2] = mk(5, 5, 0);
    init_mem[3] = mk(1, 2, 0);
    run_pass("basic", 7'd3, 0, 0, 0);
    check("basic_idx_const", best_idx, 2'd1);
    check("basic_cell_const", best_cell, 8'h99);
    check("basic_f_const", best_f, 8'd3);

    for (int i = 0; i < N; i++) init_mem[i] = mk($urandom_range(15), $urandom_range(15), 1);
    run_pass("all_empty", 7'($urandom_range(127)), 0, 0, 0);

    init_mem[0] = mk(4, 4, 1);
    init_mem[1] = mk(9, 0, 0);
    init_mem[2] = mk(2, 2, 1);
    init_mem[3] = mk(0, 9, 0);
    run_pass("tie", 7'd3, 0, 0, 0);

    for (int i = 0; i < N; i++) init_mem[i] = mk($urandom_range(15), $urandom_range(15), 0);
    run_pass("restart_busy", 7'd10, 0, 3, 0);

    for (int i = 0; i < N; i++) init_mem[i] = mk($urandom_range(15), $urandom_range(15), 0);
    run_pass("abort", 7'd5, 0, 0, 3);
    for (int i = 0; i < N; i++) init_mem[i] = mk($urandom_range(15), $urandom_range(15), 0);
    run_pass("after_abort", 7'd7, 0, 0, 0);

    for (int i = 0; i < N; i++) init_mem[i] = mk($urandom_range(15), $urandom_range(15), 0);
    run_pass("g_change", 7'd3, 2, 0, 0);

    for (int p = 0; p < 6; p++) begin
      for (int i = 0; i < N; i++)
        init_mem[i] = mk($urandom_range(15), $urandom_range(15), ($urandom_range(2) == 0));
      run_pass("random", 7'($urandom_range(127)), 0, 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
